// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared state encoding, lamp codes and sizing helper for the
//            multi-side traffic controller.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        WALK   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4
    } state_t;

    // Lamp triplets are {R,Y,G}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic int side_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_ctrl_multi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : One-second prescaler; single-cycle tick at TICK_DIV-1, clearable.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int             PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  c_last = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/traffic_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_multi
// Brief    : Main road + NUM_SIDE side roads + walk lamp, round-robin service.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int NUM_SIDE = 2,
    parameter int T_MAIN   = 6,
    parameter int T_SIDE   = 3,
    parameter int T_EXT    = 3,
    parameter int T_YEL    = 2,
    parameter int T_WALK   = 3,
    parameter int CW       = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SIDE-1:0]           sensor,
    input  logic                          button_walk,
    output logic                          light_walk,
    output logic [2:0]                    light_main,
    output logic [3*NUM_SIDE-1:0]         light_side,
    output logic [side_w(NUM_SIDE)-1:0]   srv_side
);

    localparam int            SW         = side_w(NUM_SIDE);
    localparam logic [CW-1:0] c_t_main   = CW'(T_MAIN);
    localparam logic [CW-1:0] c_t_main2  = CW'(2 * T_MAIN);
    localparam logic [CW-1:0] c_t_side   = CW'(T_SIDE);
    localparam logic [CW-1:0] c_t_sext   = CW'(T_SIDE + T_EXT);
    localparam logic [CW-1:0] c_t_yel    = CW'(T_YEL);
    localparam logic [CW-1:0] c_t_walk   = CW'(T_WALK);
    localparam logic          c_ext_en   = (T_EXT > 0);

    state_t                r_state;
    state_t                w_state_nx;
    logic [CW-1:0]         r_sec;
    logic [CW-1:0]         w_sec_inc;
    logic                  r_ext;
    logic                  w_ext_nx;
    logic [NUM_SIDE-1:0]   r_demand;
    logic [NUM_SIDE-1:0]   w_clr_mask;
    logic                  r_walk_req;
    logic [SW-1:0]         r_srv;
    logic [SW-1:0]         w_sel;
    logic [SW-1:0]         w_idx;
    logic                  w_found;
    logic                  w_tick;
    logic                  w_chg;
    logic                  w_enter_side;
    logic                  w_sensor_srv;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_chg),
        .o_tick (w_tick)
    );

    assign w_chg        = (w_state_nx != r_state);
    assign w_sec_inc    = r_sec + CW'(1);
    assign w_enter_side = (w_state_nx == SIDE_G) && (r_state != SIDE_G);
    assign w_sensor_srv = |(sensor & (NUM_SIDE'(1) << r_srv));
    assign w_clr_mask   = w_enter_side ? (NUM_SIDE'(1) << w_sel) : '0;

    // Round-robin: first pending side after the last served one, else plain rotation
    always_comb begin
        w_sel   = SW'((int'(r_srv) + 1) % NUM_SIDE);
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_SIDE; k++) begin
            w_idx = SW'((int'(r_srv) + k) % NUM_SIDE);
            if (!w_found && (|(r_demand & (NUM_SIDE'(1) << w_idx)))) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ext_nx   = r_ext;
        case (r_state)
            MAIN_G: begin
                if (w_tick && (w_sec_inc >= c_t_main) &&
                    ((|r_demand) || (w_sec_inc == c_t_main2))) begin
                    w_state_nx = MAIN_Y;
                end
            end
            MAIN_Y: begin
                if (w_tick && (w_sec_inc >= c_t_yel)) begin
                    w_state_nx = r_walk_req ? WALK : SIDE_G;
                end
            end
            WALK: begin
                if (w_tick && (w_sec_inc >= c_t_walk)) begin
                    w_state_nx = SIDE_G;
                end
            end
            SIDE_G: begin
                // A single extension is granted only at the end of the base period
                if (w_tick && (w_sec_inc >= (r_ext ? c_t_sext : c_t_side))) begin
                    if (!r_ext && c_ext_en && w_sensor_srv) begin
                        w_ext_nx = 1'b1;
                    end else begin
                        w_state_nx = SIDE_Y;
                    end
                end
            end
            SIDE_Y: begin
                if (w_tick && (w_sec_inc >= c_t_yel)) begin
                    w_state_nx = MAIN_G;
                end
            end
            default: begin
                w_state_nx = MAIN_G;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= MAIN_G;
            r_sec      <= '0;
            r_ext      <= 1'b0;
            r_demand   <= '0;
            r_walk_req <= 1'b0;
            r_srv      <= SW'(NUM_SIDE - 1);
        end else begin
            r_state <= w_state_nx;
            if (w_chg) begin
                r_sec <= '0;
                r_ext <= 1'b0;
            end else begin
                if (w_tick) begin
                    r_sec <= w_sec_inc;
                end
                r_ext <= w_ext_nx;
            end
            if (w_enter_side) begin
                r_srv <= w_sel;
            end
            r_demand   <= (r_demand | sensor) & ~w_clr_mask;
            r_walk_req <= (r_state == WALK) ? 1'b0 : (r_walk_req | button_walk);
        end
    end

    always_comb begin
        light_main = LAMP_R;
        light_walk = 1'b0;
        case (r_state)
            MAIN_G:  light_main = LAMP_G;
            MAIN_Y:  light_main = LAMP_Y;
            WALK:    light_walk = 1'b1;
            default: light_main = LAMP_R;
        endcase
    end

    for (genvar i = 0; i < NUM_SIDE; i++) begin : g_side
        assign light_side[3*i +: 3] = (r_srv != SW'(i)) ? LAMP_R :
                                      (r_state == SIDE_G) ? LAMP_G :
                                      (r_state == SIDE_Y) ? LAMP_Y : LAMP_R;
    end

    assign srv_side = r_srv;

endmodule
`default_nettype wire
